// File: rtl/hex_char_streamer.sv
// Captures a WIDTH-bit value on start and streams its hex digits as ASCII, MS nibble first,
// over a valid/ready handshake. Define HEX_STREAM_LZS_EN to blank leading zeros as spaces.
module hex_char_streamer #(
    parameter int WIDTH     = 32,
    parameter bit UPPERCASE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic [7:0]       char_out,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             done
);

    localparam int NDIG  = WIDTH / 4;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NDIG - 1);

    generate
        if (WIDTH < 4 || WIDTH > 64 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("hex_char_streamer: WIDTH must be a multiple of 4 in 4..64");
        end
    endgenerate

    // Handshake: a character transfers on a rising edge where char_valid and char_ready
    // are both 1; while char_valid=1 and char_ready=0, char_out and char_valid hold.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       char_q, char_d;

    logic [WIDTH-1:0] shadow_next;
    logic [CNT_W-1:0] cnt_next;
    logic             blank_first;
    logic             blank_next;

`ifdef HEX_STREAM_LZS_EN
    logic seen_q, seen_d;
`endif

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib, input logic blank);
        if (blank)
            return 8'h20;
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
    endfunction

    always_comb begin
        shadow_next = shadow_q << 4;
        cnt_next    = cnt_q - 1'b1;
`ifdef HEX_STREAM_LZS_EN
        // A digit is blanked only while nothing nonzero has gone out and it is not the last one.
        seen_d      = seen_q;
        blank_first = (value[WIDTH-1 -: 4] == 4'h0) && (CNT_MAX != '0);
        blank_next  = !(seen_q || (shadow_q[WIDTH-1 -: 4] != 4'h0)) &&
                      (cnt_next != '0) && (shadow_next[WIDTH-1 -: 4] == 4'h0);
`else
        blank_first = 1'b0;
        blank_next  = 1'b0;
`endif
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        char_d   = char_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SEND;
                    shadow_d = value;
                    cnt_d    = CNT_MAX;
                    char_d   = hex_ascii(value[WIDTH-1 -: 4], blank_first);
`ifdef HEX_STREAM_LZS_EN
                    seen_d   = 1'b0;
`endif
                end
            end
            ST_SEND: begin
                if (char_ready) begin
                    shadow_d = shadow_next;
`ifdef HEX_STREAM_LZS_EN
                    seen_d   = seen_q || (shadow_q[WIDTH-1 -: 4] != 4'h0);
`endif
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                        char_d  = 8'h00;
                    end else begin
                        cnt_d  = cnt_next;
                        char_d = hex_ascii(shadow_next[WIDTH-1 -: 4], blank_next);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                char_d  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            char_q   <= 8'h00;
`ifdef HEX_STREAM_LZS_EN
            seen_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            char_q   <= char_d;
`ifdef HEX_STREAM_LZS_EN
            seen_q   <= seen_d;
`endif
        end
    end

    // Every output is a flop or a decode of the state flop; char_ready never reaches them.
    assign busy       = (state_q != ST_IDLE);
    assign char_valid = (state_q == ST_SEND);
    assign done       = (state_q == ST_DONE);
    assign char_out   = char_q;

endmodule

// File: tb/tb_hex_char_streamer.sv
// Randomized bench for hex_char_streamer: a 32-bit uppercase instance with a scoreboard
// monitor, plus a 16-bit lowercase instance driven with directed timing checks.
module tb_hex_char_streamer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready;
    logic        done;

    logic        u_start;
    logic [15:0] u_value;
    logic        u_busy;
    logic [7:0]  u_char_out;
    logic        u_char_valid;
    logic        u_char_ready;
    logic        u_done;

    int n_checks = 0;
    int n_errors = 0;
    int started = 0;
    int done_count = 0;
    int ready_mode = 0;

    logic [7:0] exp_q[$];

    hex_char_streamer #(.WIDTH(32), .UPPERCASE(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .value(value), .busy(busy),
        .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready), .done(done)
    );

    hex_char_streamer #(.WIDTH(16), .UPPERCASE(1'b0)) dut_lc (
        .clk(clk), .reset(reset), .start(u_start), .value(u_value), .busy(u_busy),
        .char_out(u_char_out), .char_valid(u_char_valid), .char_ready(u_char_ready), .done(u_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Character idx (0 = most significant) of an ndig-digit hex rendering of v.
    function automatic logic [7:0] model_char(input logic [63:0] v, input int ndig,
                                              input int idx, input bit upper);
        int nib;
        bit lead;
        nib = int'((v >> (4 * (ndig - 1 - idx))) & 64'hF);
        lead = 1'b1;
        for (int j = 0; j < idx; j++)
            if (((v >> (4 * (ndig - 1 - j))) & 64'hF) != 0) lead = 1'b0;
`ifdef HEX_STREAM_LZS_EN
        if (nib == 0 && lead && idx != ndig - 1) return 8'h20;
`endif
        if (nib < 10) return 8'(48 + nib);
        return 8'((upper ? 65 : 97) + nib - 10);
    endfunction

    // Ready driver: 0 = always ready, 1 = random, 2 = pattern 1,0,0 repeating.
    initial begin
        int pat;
        pat = 0;
        char_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: char_ready = 1'b1;
                1: char_ready = 1'($urandom_range(0, 1));
                default: begin
                    char_ready = (pat % 3 == 0);
                    pat++;
                end
            endcase
        end
    end

    // Scoreboard monitor for the 32-bit instance.
    initial begin
        bit stall_prev;
        bit done_prev;
        logic [7:0] stall_char;
        logic [7:0] exp_c;
        stall_prev = 1'b0;
        done_prev = 1'b0;
        stall_char = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
                done_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid_hold", char_valid, 1'b1);
                    check("stall_char_hold", char_out, stall_char);
                end
                if (char_valid && char_ready) begin
                    check("char_expected", (exp_q.size() != 0), 1'b1);
                    if (exp_q.size() != 0) begin
                        exp_c = exp_q.pop_front();
                        check("char_value", char_out, exp_c);
                    end
                end
                if (done) begin
                    done_count++;
                    check("done_after_last", exp_q.size(), 0);
                    check("done_one_cycle", done_prev, 1'b0);
                end
                stall_prev = char_valid && !char_ready;
                stall_char = char_out;
                done_prev = done;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    // Called at posedge+1; the start is accepted at the next edge.
    task automatic start_stream(input logic [31:0] v);
        wait_idle();
        start = 1'b1;
        value = v;
        for (int i = 0; i < 8; i++) exp_q.push_back(model_char(64'(v), 8, i, 1'b1));
        started++;
        @(posedge clk);
        #1;
        start = 1'b0;
        value = $urandom;
    endtask

    task automatic run_lc(input logic [15:0] v);
        u_start = 1'b1;
        u_value = v;
        @(posedge clk);
        #1;
        u_start = 1'b0;
        u_value = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("lc_valid", u_char_valid, 1'b1);
            check("lc_char", u_char_out, model_char(64'(v), 4, k, 1'b0));
        end
        @(negedge clk);
        check("lc_done", u_done, 1'b1);
        check("lc_done_valid_low", u_char_valid, 1'b0);
        @(negedge clk);
        check("lc_busy_low", u_busy, 1'b0);
        check("lc_done_low", u_done, 1'b0);
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        u_start = 1'b0;
        u_value = '0;
        u_char_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", char_valid, 1'b0);
        check("rst_char", char_out, 8'h00);
        check("rst_done", done, 1'b0);
        check("rst_lc_busy", u_busy, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back transfers and exact cycle timing.
        ready_mode = 0;
        start_stream(32'h1234ABCD);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t1_valid", char_valid, 1'b1);
            check("t1_busy", busy, 1'b1);
            check("t1_char", char_out, model_char(64'h1234ABCD, 8, k, 1'b1));
        end
        @(negedge clk);
        check("t1_done", done, 1'b1);
        check("t1_done_busy", busy, 1'b1);
        check("t1_done_valid", char_valid, 1'b0);
        @(negedge clk);
        check("t1_busy_low", busy, 1'b0);
        check("t1_done_low", done, 1'b0);
        @(posedge clk);
        #1;

        // Stalls with a 1,0,0 ready pattern.
        ready_mode = 2;
        start_stream(32'h1234ABCD);
        wait_idle();
        check("t2_done_count", done_count, started);

        // Zero-heavy values (leading-zero handling when enabled).
        ready_mode = 0;
        start_stream(32'h000000A0);
        start_stream(32'h00000000);
        start_stream(32'h80000001);
        wait_idle();
        check("t3_done_count", done_count, started);

        // Lowercase 16-bit instance.
        run_lc(16'hBEEF);
        run_lc(16'h0000);
        for (int i = 0; i < 3; i++) run_lc(16'($urandom));

        // start while busy must be ignored.
        @(posedge clk);
        #1;
        start_stream(32'h1234ABCD);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b1;
        value = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        check("t5_done_count", done_count, started);
        check("t5_queue_empty", exp_q.size(), 0);

        // Reset in the middle of the 5th character.
        start_stream(32'h1234ABCD);
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("t6_valid", char_valid, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_done", done, 1'b0);
        check("t6_char", char_out, 8'h00);
        check("t6_sent_four", exp_q.size(), 4);
        exp_q.delete();
        started--;
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        start_stream($urandom);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        check("t6_done_count", done_count, started);

        // Randomized streams with random back-pressure.
        for (int i = 0; i < 25; i++) begin
            ready_mode = $urandom_range(0, 2);
            v = $urandom >> $urandom_range(0, 31);
            start_stream(v);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rand_done_count", done_count, started);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
